// File: rtl/xpb_lut_ram.sv
// rtl/xpb_lut_ram.sv - streamed-load multi-table lookup RAM; optional output stage via XPB_LUT_OUT_REG_EN
module xpb_lut_ram #(
   parameter int DATA_W     = 1024,
   parameter int IDX_W      = 5,
   parameter int NUM_TABLES = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cfg_start,
   input  logic                           cfg_valid,
   output logic                           cfg_ready,
   input  logic [DATA_W-1:0]              cfg_data,
   output logic                           tables_ready,
   input  logic                           rd_valid,
   input  logic [NUM_TABLES*IDX_W-1:0]    rd_index,
   output logic                           out_valid,
   output logic [NUM_TABLES*DATA_W-1:0]   rd_data
);

   localparam int DEPTH = 2 ** IDX_W;
   localparam int TBL_W = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
   localparam logic [TBL_W-1:0] LAST_TBL = TBL_W'(NUM_TABLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = '1;
   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);

   typedef enum logic {LOAD, RUN} state_t;

   state_t                          state;
   state_t                          state_next;
   logic [TBL_W-1:0]                wr_tbl;
   logic [IDX_W-1:0]                wr_idx;
   logic                            accept;
   logic                            last_word;
   logic                            wr_en;
   logic                            run;
   logic [NUM_TABLES*DATA_W-1:0]    lookup;
   logic                            s1_valid;
   logic [NUM_TABLES*DATA_W-1:0]    s1_data;

   assign run       = (state == RUN);
   assign accept    = (state == LOAD) && cfg_valid && !cfg_start;
   assign last_word = (wr_tbl == LAST_TBL) && (wr_idx == LAST_IDX);
   assign wr_en     = accept && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      cfg_ready    = 1'b0;
      tables_ready = 1'b0;
      case (state)
         LOAD: begin
            cfg_ready = 1'b1;
            if (accept && last_word) begin
               state_next = RUN;
            end
         end
         RUN: begin
            tables_ready = 1'b1;
         end
         default: begin
            state_next = LOAD;
         end
      endcase
      if (cfg_start) begin
         state_next = LOAD;
      end
   end

   // Write pointer skips index 0 of each table; it is the hard-wired zero entry.
   always_ff @(posedge clk) begin
      if (reset || cfg_start) begin
         wr_tbl <= '0;
         wr_idx <= FIRST_IDX;
      end else if (accept) begin
         if (wr_idx == LAST_IDX) begin
            wr_idx <= FIRST_IDX;
            wr_tbl <= last_word ? '0 : wr_tbl + 1'b1;
         end else begin
            wr_idx <= wr_idx + 1'b1;
         end
      end
   end

   for (genvar t = 0; t < NUM_TABLES; t++) begin : g_tbl
      logic [DATA_W-1:0] mem [DEPTH];
      logic [IDX_W-1:0]  idx;

      assign idx = rd_index[t*IDX_W +: IDX_W];

      always_ff @(posedge clk) begin
         if (wr_en && (wr_tbl == TBL_W'(t))) begin
            mem[wr_idx] <= cfg_data;
         end
      end

      assign lookup[t*DATA_W +: DATA_W] = (idx == '0) ? '0 : mem[idx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= rd_valid && run;
         if (rd_valid && run) begin
            s1_data <= lookup;
         end
      end
   end

`ifdef XPB_LUT_OUT_REG_EN
   logic                            s2_valid;
   logic [NUM_TABLES*DATA_W-1:0]    s2_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= s1_data;
         end
      end
   end

   assign out_valid = s2_valid;
   assign rd_data   = s2_data;
`else
   assign out_valid = s1_valid;
   assign rd_data   = s1_data;
`endif

endmodule
